// File: rtl/eightbit_mem.sv
// 256-byte RAM plus a 4-register console I/O window (TX FIFO, RX holding register)
// for the eightbit CPU bus. Every edge is a bus cycle; rdata is registered.
module eightbit_mem #(
  parameter logic [7:0] IO_BASE  = 8'hF8,
  parameter int         TX_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  output logic [7:0] rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem  [256];
  logic [7:0]    r_fifo [TX_DEPTH];
  logic [PW-1:0] r_rptr, r_wptr;
  logic [CW-1:0] r_cnt;
  logic          r_ovf, r_rx_avail;
  logic [7:0]    r_rx_byte, r_rdata;

  logic       w_io, w_full, w_empty, w_pop, w_push, w_push_ok, w_drop;
  logic       w_ovf_clr, w_rx_rd, w_rx_cap;
  logic [1:0] w_off;
  logic [7:0] w_rd;

  assign w_io      = (addr[7:2] == IO_BASE[7:2]);
  assign w_off     = addr[1:0];
  assign w_full    = (r_cnt == CW'(TX_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_pop     = !w_empty && tx_ready;
  assign w_push    = we && w_io && (w_off == 2'd1);
  // A pop in the same edge frees the slot, so a push to a full FIFO still lands.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && !w_push_ok;
  assign w_ovf_clr = we && w_io && (w_off == 2'd0) && wdata[3];
  assign w_rx_rd   = w_io && (w_off == 2'd2);
  assign w_rx_cap  = rx_valid && !r_rx_avail;

  always_comb begin
    w_rd = 8'h00;
    if (!w_io) begin
      w_rd = we ? wdata : r_mem[addr];
    end else begin
      case (w_off)
        2'd0:    w_rd = {4'b0, r_ovf, r_rx_avail, w_empty, w_full};
        2'd1:    w_rd = 8'h00;
        2'd2:    w_rd = r_rx_avail ? r_rx_byte : 8'h00;
        default: w_rd = 8'(r_cnt);
      endcase
    end
  end

  // Storage arrays carry no reset: RAM survives reset, FIFO slots are masked by count.
  always_ff @(posedge clk) begin
    if (we && !w_io) r_mem[addr] <= wdata;
    if (w_push_ok)   r_fifo[r_wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata    <= 8'h00;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_rx_avail <= 1'b0;
      r_rx_byte  <= 8'h00;
    end else begin
      r_rdata <= w_rd;
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_rx_rd && r_rx_avail) begin
        r_rx_avail <= 1'b0;
      end else if (w_rx_cap) begin
        r_rx_avail <= 1'b1;
        r_rx_byte  <= rx_data;
      end
    end
  end

  assign rdata    = r_rdata;
  assign tx_valid = !w_empty;
  assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rptr];
  assign rx_ready = !r_rx_avail;

endmodule

// File: tb/tb_eightbit_mem.sv
// Bench for eightbit_mem: queue/array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_eightbit_mem;
  localparam logic [7:0] IOB = 8'hF8;
  localparam int         D   = 8;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00, rx_data = 8'h00;
  logic       we = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0] rdata, tx_data;
  logic       tx_valid, rx_ready;

  int n_vec = 0, n_err = 0;

  eightbit_mem #(.IO_BASE(IOB), .TX_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_ram [256];
  bit         m_known [256];
  logic [7:0] m_q [$];
  bit         m_ovf, m_rx_avail, m_rd_known;
  logic [7:0] m_rx_byte, m_rd;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit io, was_full, pop, push;
    int off;
    io  = (addr >= IOB) && (addr <= IOB + 8'd3);
    off = int'(addr) - int'(IOB);
    if (!io) begin
      if (we) begin
        m_rd = wdata; m_rd_known = 1;
        m_ram[addr] = wdata; m_known[addr] = 1;
      end else begin
        m_rd = m_ram[addr]; m_rd_known = m_known[addr];
      end
    end else begin
      m_rd_known = 1;
      case (off)
        0: m_rd = {4'b0, m_ovf, m_rx_avail, m_q.size() == 0, m_q.size() == D};
        1: m_rd = 8'h00;
        2: m_rd = m_rx_avail ? m_rx_byte : 8'h00;
        default: m_rd = 8'(m_q.size());
      endcase
    end
    was_full = (m_q.size() == D);
    pop  = (m_q.size() != 0) && tx_ready;
    push = we && io && (off == 1);
    if (pop) void'(m_q.pop_front());
    if (push && (!was_full || pop)) m_q.push_back(wdata);
    else if (push) m_ovf = 1;
    else if (we && io && off == 0 && wdata[3]) m_ovf = 0;
    if (io && off == 2 && m_rx_avail) m_rx_avail = 0;
    else if (rx_valid && !m_rx_avail) begin
      m_rx_avail = 1; m_rx_byte = rx_data;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 0; m_rx_avail = 0; m_rx_byte = 8'h00;
      m_rd = 8'h00; m_rd_known = 1;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_rd_known) chk("rdata", rdata, m_rd);
      chk("tx_valid", {7'b0, tx_valid}, {7'b0, m_q.size() != 0});
      if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
      chk("rx_ready", {7'b0, rx_ready}, {7'b0, !m_rx_avail});
    end
  end

  task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic w);
    addr = a; wdata = d; we = w;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);

    // RAM path
    cyc(8'h10, 8'hA5, 1'b1);
    cyc(8'h10, 8'h00, 1'b0);
    chk("ram_rd", rdata, 8'hA5);
    cyc(8'hFF, 8'h5A, 1'b1);
    chk("ram_wfirst", rdata, 8'h5A);

    // TX burst with overflow
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) cyc(IOB + 8'd1, 8'(i), 1'b1);
    cyc(IOB + 8'd3, 8'h00, 1'b0);
    chk("txcount_full", rdata, 8'h08);
    cyc(IOB, 8'h00, 1'b0);
    chk("status_full_ovf", rdata, 8'h09);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", {7'b0, tx_valid}, 8'h01);
      chk("drain_data", tx_data, 8'(i));
      cyc(IOB, 8'h00, 1'b0);
    end
    chk("drain_empty", {7'b0, tx_valid}, 8'h00);
    cyc(IOB, 8'h00, 1'b0);
    chk("status_empty_ovf", rdata, 8'h0A);
    cyc(IOB, 8'h08, 1'b1);
    cyc(IOB, 8'h00, 1'b0);
    chk("status_ovf_clr", rdata, 8'h02);

    // Push and pop while full
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc(IOB + 8'd1, 8'h10 + 8'(i), 1'b1);
    tx_ready = 1'b1;
    cyc(IOB + 8'd1, 8'h55, 1'b1);
    tx_ready = 1'b0;
    cyc(IOB + 8'd3, 8'h00, 1'b0);
    chk("pp_count", rdata, 8'h08);
    cyc(IOB, 8'h00, 1'b0);
    chk("pp_status", rdata, 8'h01);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("pp_data", tx_data, (i < 7) ? 8'h11 + 8'(i) : 8'h55);
      cyc(8'h10, 8'h00, 1'b0);
    end
    chk("pp_empty", {7'b0, tx_valid}, 8'h00);

    // RX holding register
    rx_valid = 1'b1; rx_data = 8'h3C;
    cyc(8'h10, 8'h00, 1'b0);
    chk("rx_blocked", {7'b0, rx_ready}, 8'h00);
    rx_data = 8'h7E;
    cyc(IOB, 8'h00, 1'b0);
    chk("rx_status", rdata, 8'h06);
    cyc(IOB + 8'd2, 8'h00, 1'b0);
    chk("rx_read1", rdata, 8'h3C);
    chk("rx_ready_after_rd", {7'b0, rx_ready}, 8'h01);
    cyc(8'h10, 8'h00, 1'b0);
    rx_valid = 1'b0;
    chk("rx_second_cap", {7'b0, rx_ready}, 8'h00);
    cyc(IOB + 8'd2, 8'h00, 1'b0);
    chk("rx_read2", rdata, 8'h7E);
    cyc(IOB + 8'd2, 8'h00, 1'b0);
    chk("rx_read_empty", rdata, 8'h00);

    // Reset mid-traffic
    tx_ready = 1'b0;
    cyc(8'h20, 8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) cyc(IOB + 8'd1, 8'hE0 + 8'(i), 1'b1);
    rx_valid = 1'b1; rx_data = 8'h99;
    cyc(IOB + 8'd3, 8'h00, 1'b0);
    rx_valid = 1'b0;
    chk("pre_rst_count", rdata, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdata", rdata, 8'h00);
    chk("arst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("arst_tx_data", tx_data, 8'h00);
    chk("arst_rx_ready", {7'b0, rx_ready}, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(IOB + 8'd3, 8'h00, 1'b0);
    chk("post_rst_count", rdata, 8'h00);
    cyc(8'h20, 8'h00, 1'b0);
    chk("ram_survives", rdata, 8'hC3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 5)      a = IOB + 8'($urandom_range(0, 3));
      else if (r < 8) a = 8'($urandom_range(0, 15));
      else            a = 8'($urandom);
      addr  = a;
      wdata = 8'($urandom);
      we    = (a == IOB + 8'd1) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 3) == 0);
      tx_ready = ($urandom_range(0, 3) == 0);
      if (!(rx_valid && !rx_ready)) begin
        rx_valid = $urandom_range(0, 1) == 1;
        rx_data  = 8'($urandom);
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
